instr_fetch_unit: RTL
=====================

// Module: instr_fetch_unit
// PURPOSE
//  Fetch stage of the single-issue RV32 subset core, feeding the control unit. Holds the PC and
//  issues one instruction-memory request at a time (valid/ready request, valid-only response).
//  Presents the fetched word with decoded opcode/funct3/funct7 and branch/JAL immediates.
//  Picks the next PC from the control unit's pc_source_code when the core consumes the instruction.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded on reset; must be word aligned
// PORTS
//  clk             in   1   single clock; all state on rising edge
//  rst             in   1   synchronous, active-high reset
//  imem_req_valid  out  1   fetch request valid
//  imem_req_addr   out  32  fetch address (= pc)
//  imem_req_ready  in   1   memory accepts request this cycle
//  imem_rsp_valid  in   1   read data valid
//  imem_rsp_data   in   32  instruction word
//  instr_valid     out  1   instr/pc/decoded fields valid
//  instr_ready     in   1   core consumes the instruction this cycle
//  pc_source_code  in   2   00 pc+4, 01 pc+imm_b, 10 pc+imm_j, 11 treated as 00
//  instr           out  32  held instruction word
//  pc              out  32  address of instr
//  pc_plus4        out  32  pc+4, for the JAL link write
//  opcode          out  7   instr[6:0]
//  funct3          out  3   instr[14:12]
//  funct7          out  1   instr[30]
//  imm_b           out  32  sign-extended {instr[31],instr[7],instr[30:25],instr[11:8],1'b0}
//  imm_j           out  32  sign-extended {instr[31],instr[19:12],instr[20],instr[30:21],1'b0}
//  instret         out  32  count of consumed instructions
// BEHAVIOUR
//  - FSM: S_IDLE -> S_REQ -> S_WAIT -> S_HOLD -> S_REQ ...
//    S_IDLE: entered on rst. Advances to S_REQ next cycle unconditionally.
//    S_REQ: imem_req_valid=1, imem_req_addr=pc. If imem_req_ready, go to S_WAIT.
//    S_WAIT: on imem_rsp_valid, latch imem_rsp_data into instr and go to S_HOLD.
//    S_HOLD: instr_valid=1. If instr_ready: pc <= next_pc, instret += 1, go to S_REQ.
//  - Reset values: pc=RESET_PC, instr=32'h0000_0013 (nop), instret=0, state=S_IDLE.
//    imem_req_valid=0 and instr_valid=0. Decoded outputs follow the reset instr.
//  - imem_req_valid and instr_valid are decoded from state only.
//    Neither depends combinationally on ready inputs.
//  - imem_req_addr is stable while imem_req_valid=1 and ready=0.
//  - Latency: request accepted in cycle N -> earliest rsp in N+1 -> instr_valid in N+2.
//    imem_rsp_valid outside S_WAIT is ignored; the memory shares rst and drops in-flight reads.
//  - Decoded fields and immediates are combinational from the held instr register.
//    They are stable for the whole S_HOLD period.
//  - next_pc: 00/11 -> pc+4; 01 -> pc+imm_b; 10 -> pc+imm_j.
//    All sums are 32-bit modulo 2^32 (wrap, no flag).
//    next_pc[1:0] is forced to 2'b00.
//  - pc_source_code is sampled only in the S_HOLD cycle where instr_ready=1; ignored otherwise.
//  - instret wraps 32'hFFFF_FFFF -> 0.
//  - rst overrides everything in every state, including mid-request and mid-hold.
//    An instruction in S_HOLD is discarded and not counted.
// TESTING
//  - Reset, RESET_PC=0, ready=1, 1-cycle memory: addresses 0,4,8 fetched in order.
//    instret=3 after three consumes.
//  - Hold instr_ready=0 for 5 cycles in S_HOLD: instr/pc stable, no new request, instret unchanged.
//  - At pc=0x20, beq word 0x00000863 (imm_b=+16), pc_source_code=01: next fetch address 0x30.
//  - At pc=0x40, jal 0xFF9FF0EF (imm_j=-8), code=10: next fetch address 0x38, pc_plus4=0x44.
//  - imem_req_ready low 3 cycles, then rsp delayed 4 cycles: address held, single request.
//    A stray rsp_valid in S_REQ is ignored.
//  - rst asserted in S_WAIT: next cycle S_IDLE, pc=RESET_PC. The late rsp is ignored.
//    pc=0xFFFFFFFC with code=00 wraps to 0.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Fetch stage for the RV32 subset core: one outstanding imem request, holds the fetched word
// with its decoded fields until the core consumes it, then steps the PC.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic [1:0]  pc_source_code,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic        funct7,
  output logic [31:0] imm_b,
  output logic [31:0] imm_j,
  output logic [31:0] instret
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instret_q, instret_d;
  logic [31:0] target_sum;
  logic [31:0] next_pc;
  logic        consume;

  // NOTE: reset is synchronous, so it lives inside the clocked branch; state uses <= only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      instr_q   <= NOP;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      instret_q <= instret_d;
    end
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ:  if (imem_req_ready) state_d = S_WAIT;
      S_WAIT: if (imem_rsp_valid) state_d = S_HOLD;
      S_HOLD: if (instr_ready)    state_d = S_REQ;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req_valid = (state_q == S_REQ);
    instr_valid    = (state_q == S_HOLD);
  end

  assign consume = (state_q == S_HOLD) && instr_ready;

  // Branch/jump targets wrap modulo 2^32; the low bits are cleared to keep fetches aligned.
  always_comb begin
    unique case (pc_source_code)
      2'b01:   target_sum = pc_q + imm_b;
      2'b10:   target_sum = pc_q + imm_j;
      default: target_sum = pc_q + 32'd4;
    endcase
    next_pc = {target_sum[31:2], 2'b00};
  end

  always_comb begin
    pc_d      = pc_q;
    instr_d   = instr_q;
    instret_d = instret_q;
    if ((state_q == S_WAIT) && imem_rsp_valid) instr_d = imem_rsp_data;
    if (consume) begin
      pc_d      = next_pc;
      instret_d = instret_q + 32'd1;
    end
  end

  assign imem_req_addr = pc_q;
  assign instr         = instr_q;
  assign pc            = pc_q;
  assign pc_plus4      = pc_q + 32'd4;
  assign instret       = instret_q;
  assign opcode        = instr_q[6:0];
  assign funct3        = instr_q[14:12];
  assign funct7        = instr_q[30];
  assign imm_b = {{20{instr_q[31]}}, instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
  assign imm_j = {{12{instr_q[31]}}, instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0};

endmodule
